// File: rtl/eth_phy_link_pkg.sv
// Shared definitions for the 10G PHY receive link bring-up sequencer.
package eth_phy_link_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 3'd0,
        SERDES_RST = 3'd1,
        WAIT_LOCK  = 3'd2,
        STABILIZE  = 3'd3,
        LINK_UP    = 3'd4,
        FAULT      = 3'd5
    } link_state_e;

endpackage

// File: rtl/eth_phy_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module eth_phy_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear first, otherwise increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/eth_phy_link_ctrl.sv
// Receive-side link bring-up sequencer: SerDes reset, lock wait with
// timeout and bounded retries, lock/BER debounce, link up, sticky fault.
module eth_phy_link_ctrl
    import eth_phy_link_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT  = 1000,
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned STABLE_CYCLES = 125,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                 rx_clk,
    input  logic                 rx_rst,
    input  logic                 cfg_enable,
    input  logic                 cfg_restart,
    input  logic                 cfg_clear_counters,
    input  logic                 rx_block_lock,
    input  logic                 rx_high_ber,
    input  logic                 rx_bad_block,
    output logic                 serdes_rx_reset_req,
    output logic                 link_up,
    output logic                 link_fault,
    output logic [STATE_W-1:0]   state,
    output logic [3:0]           retry_count,
    output logic [7:0]           flap_count,
    output logic [CNT_WIDTH-1:0] bad_block_count
);

    // One shared timer serves every timed state, so size it for the longest.
    localparam int unsigned TMR_MAX_A = (LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES;
    localparam int unsigned TMR_MAX   = (TMR_MAX_A > STABLE_CYCLES) ? TMR_MAX_A : STABLE_CYCLES;
    localparam int unsigned TMR_W     = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

    link_state_e      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [3:0]       retry_q, retry_d;
    logic             req_q, link_up_q, fault_q;
    logic             good;
    logic             flap_inc;
    logic             bad_inc;

    assign good = rx_block_lock & ~rx_high_ber;

    // Next-state, timer and retry logic; enable and restart override the sequence.
    always_comb begin
        state_d  = state_q;
        timer_d  = '0;
        retry_d  = retry_q;
        flap_inc = 1'b0;
        if (!cfg_enable) begin
            state_d = IDLE;
            retry_d = '0;
        end else if (cfg_restart && (state_q != IDLE)) begin
            state_d = SERDES_RST;
            retry_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SERDES_RST;
                end
                SERDES_RST: begin
                    if (timer_q == TMR_W'(RESET_CYCLES - 1)) begin
                        state_d = WAIT_LOCK;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (good) begin
                        state_d = STABILIZE;
                    end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                        if (retry_q == 4'(MAX_RETRIES)) begin
                            state_d = FAULT;
                        end else begin
                            state_d = SERDES_RST;
                            retry_d = retry_q + 4'd1;
                        end
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                STABILIZE: begin
                    if (!good) begin
                        state_d = WAIT_LOCK;
                    end else if (timer_q == TMR_W'(STABLE_CYCLES - 1)) begin
                        state_d = LINK_UP;
                        retry_d = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                LINK_UP: begin
                    if (!good) begin
                        state_d  = WAIT_LOCK;
                        flap_inc = 1'b1;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bad_inc = (state_q == LINK_UP) & rx_bad_block;

    // State, timer and registered status outputs derived from the next state.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            retry_q   <= '0;
            req_q     <= 1'b0;
            link_up_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            req_q     <= (state_d == SERDES_RST);
            link_up_q <= (state_d == LINK_UP);
            fault_q   <= (state_d == FAULT);
        end
    end

    eth_phy_sat_counter #(
        .WIDTH (8)
    ) u_flap_cnt (
        .clk_i   (rx_clk),
        .rst_i   (rx_rst),
        .clr_i   (cfg_clear_counters),
        .inc_i   (flap_inc),
        .count_o (flap_count)
    );

    eth_phy_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_bad_cnt (
        .clk_i   (rx_clk),
        .rst_i   (rx_rst),
        .clr_i   (cfg_clear_counters),
        .inc_i   (bad_inc),
        .count_o (bad_block_count)
    );

    assign serdes_rx_reset_req = req_q;
    assign link_up             = link_up_q;
    assign link_fault          = fault_q;
    assign state               = state_q;
    assign retry_count         = retry_q;

endmodule

// File: tb/tb_eth_phy_link_ctrl.sv
// Self-checking bench for eth_phy_link_ctrl: directed scenarios plus
// randomized traffic, all compared each cycle against a reference model.
module tb_eth_phy_link_ctrl;

    localparam int LT = 20;
    localparam int RC = 4;
    localparam int SC = 8;
    localparam int MR = 2;
    localparam int CW = 16;
    localparam int BAD_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en, restart, clr, lock, ber, bad;
    logic          req, lu, flt;
    logic [2:0]    state;
    logic [3:0]    retry;
    logic [7:0]    flap;
    logic [CW-1:0] bbc;

    int checks = 0;
    int errors = 0;

    // Reference model: phase, time spent in phase, and counters.
    int m_state, m_timer, m_retry, m_flap, m_bad;

    always #5 clk = ~clk;

    eth_phy_link_ctrl #(
        .LOCK_TIMEOUT  (LT),
        .RESET_CYCLES  (RC),
        .STABLE_CYCLES (SC),
        .MAX_RETRIES   (MR),
        .CNT_WIDTH     (CW)
    ) dut (
        .rx_clk              (clk),
        .rx_rst              (rst),
        .cfg_enable          (en),
        .cfg_restart         (restart),
        .cfg_clear_counters  (clr),
        .rx_block_lock       (lock),
        .rx_high_ber         (ber),
        .rx_bad_block        (bad),
        .serdes_rx_reset_req (req),
        .link_up             (lu),
        .link_fault          (flt),
        .state               (state),
        .retry_count         (retry),
        .flap_count          (flap),
        .bad_block_count     (bbc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_timer = 0; m_retry = 0; m_flap = 0; m_bad = 0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit good;
        int ns, nt, nr;
        if (rst) begin
            model_reset();
            return;
        end
        good = lock && !ber;
        if (clr) begin
            m_flap = 0;
            m_bad  = 0;
        end else begin
            if (m_state == 4 && bad && m_bad < BAD_MAX) m_bad++;
            if (m_state == 4 && en && !restart && !good && m_flap < 255) m_flap++;
        end
        ns = m_state; nt = 0; nr = m_retry;
        if (!en) begin
            ns = 0; nr = 0;
        end else if (restart && m_state != 0) begin
            ns = 1; nr = 0;
        end else if (m_state == 0) begin
            ns = 1;
        end else if (m_state == 1) begin
            if (m_timer + 1 >= RC) ns = 2; else nt = m_timer + 1;
        end else if (m_state == 2) begin
            if (good) ns = 3;
            else if (m_timer + 1 >= LT) begin
                if (m_retry >= MR) ns = 5;
                else begin ns = 1; nr = m_retry + 1; end
            end else nt = m_timer + 1;
        end else if (m_state == 3) begin
            if (!good) ns = 2;
            else if (m_timer + 1 >= SC) begin ns = 4; nr = 0; end
            else nt = m_timer + 1;
        end else if (m_state == 4) begin
            if (!good) ns = 2;
        end
        m_state = ns; m_timer = nt; m_retry = nr;
    endtask

    // One clock: update model at the edge, then compare every output.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("state", 32'(state), m_state);
        check("serdes_rx_reset_req", 32'(req), (m_state == 1) ? 1 : 0);
        check("link_up", 32'(lu), (m_state == 4) ? 1 : 0);
        check("link_fault", 32'(flt), (m_state == 5) ? 1 : 0);
        check("retry_count", 32'(retry), m_retry);
        check("flap_count", 32'(flap), m_flap);
        check("bad_block_count", 32'(bbc), m_bad);
    endtask

    task automatic wait_state(input int s, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (32'(state) == s) break;
            tick();
        end
        check("wait_state", 32'(state), s);
    endtask

    initial begin
        int pulses, hi_cycles, prev_req, flap_saved;
        int retry_seen[3];

        rst = 1'b1; en = 1'b0; restart = 1'b0; clr = 1'b0;
        lock = 1'b0; ber = 1'b0; bad = 1'b0;
        model_reset();
        tick(); tick();
        check("reset_state", 32'(state), 0);
        check("reset_req", 32'(req), 0);
        rst = 1'b0;
        tick();

        // 1. Clean bring-up, lock from cycle 10.
        en = 1'b1;
        hi_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 10) lock = 1'b1;
            tick();
            if (req) hi_cycles++;
        end
        check("s1_req_cycles", hi_cycles, RC);
        check("s1_link_up", 32'(lu), 1);
        check("s1_retry", 32'(retry), 0);

        // 2. Timeout to fault with three reset pulses.
        lock = 1'b0; restart = 1'b1;
        pulses = 0; hi_cycles = 0; prev_req = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            restart = 1'b0;
            if (req) hi_cycles++;
            if (req && prev_req == 0) begin
                if (pulses < 3) retry_seen[pulses] = 32'(retry);
                pulses++;
            end
            prev_req = 32'(req);
            if (state == 3'd5) break;
        end
        check("s2_pulses", pulses, 3);
        check("s2_req_cycles", hi_cycles, 3 * RC);
        check("s2_retry0", retry_seen[0], 0);
        check("s2_retry1", retry_seen[1], 1);
        check("s2_retry2", retry_seen[2], 2);
        check("s2_state_fault", 32'(state), 5);
        check("s2_link_fault", 32'(flt), 1);
        tick(); tick();
        check("s2_fault_sticky", 32'(state), 5);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("s2_restart_state", 32'(state), 1);
        check("s2_restart_retry", 32'(retry), 0);

        // 3. Debounce: one bad cycle at good-cycle 5 of STABILIZE.
        lock = 1'b1;
        wait_state(3, 50);
        flap_saved = 32'(flap);
        for (int i = 0; i < 4; i++) tick();
        lock = 1'b0;
        tick();
        check("s3_back_to_wait", 32'(state), 2);
        check("s3_flap_same", 32'(flap), flap_saved);
        lock = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("s3_not_up_yet", 32'(lu), 0);
        tick();
        check("s3_link_up", 32'(lu), 1);

        // 4. Bad blocks, a flap, then flap saturation.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        bad = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bad = 1'b0;
        ber = 1'b1;
        tick();
        ber = 1'b0;
        check("s4_bad_count", 32'(bbc), 3);
        check("s4_flap_count", 32'(flap), 1);
        check("s4_state", 32'(state), 2);
        for (int f = 0; f < 300; f++) begin
            wait_state(4, 30);
            ber = 1'b1;
            tick();
            ber = 1'b0;
        end
        check("s4_flap_sat", 32'(flap), 255);

        // 5. Priority: clear vs bad strobe, disable vs restart.
        wait_state(4, 30);
        clr = 1'b1; bad = 1'b1;
        tick();
        clr = 1'b0; bad = 1'b0;
        check("s5_bad_cleared", 32'(bbc), 0);
        check("s5_flap_cleared", 32'(flap), 0);
        en = 1'b0; restart = 1'b1;
        tick();
        restart = 1'b0;
        check("s5_disable_wins", 32'(state), 0);
        en = 1'b1;

        // 6. Async reset two cycles into SERDES_RST.
        lock = 1'b0;
        tick();
        tick(); tick();
        check("s6_in_reset_state", 32'(state), 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("s6_req_dropped", 32'(req), 0);
        check("s6_state_zero", 32'(state), 0);
        check("s6_outputs_zero", {16'(bbc), 8'(flap), 4'(retry), 1'b0, lu, flt, req}, 0);
        tick();
        rst = 1'b0;
        tick();
        check("s6_restart_from_idle", 32'(state), 1);

        // Randomized traffic with bursty lock.
        lock = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            en      = ($urandom_range(0, 99) != 0);
            restart = ($urandom_range(0, 149) == 0);
            clr     = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 14) == 0) lock = ~lock;
            ber     = ($urandom_range(0, 39) == 0);
            bad     = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
